// File: rtl/tropical_pkg.sv
// Shared min-plus definitions used by the tropical ALU and the matrix-vector sequencer.
package tropical_pkg;

    localparam int unsigned N    = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned IDXW = 2;

    // Canonical infinity: all ones (bit W-1 set marks any value as infinite)
    localparam logic [W-1:0] INF = {W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/tropical_op_unit.sv
// Fused accumulator update: result = OPLUS(acc, OTIMES(a, b)), bit-exact with the tropical ALU.
module tropical_op_unit
    import tropical_pkg::*;
(
    input  logic [W-1:0] acc,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result_c
);

    logic [W-2:0] sum_c;
    logic [W-1:0] prod_c;

    // OTIMES: infinity absorbs; finite sum wraps with the infinity bit forced clear
    always_comb begin
        sum_c  = a[W-2:0] + b[W-2:0];
        prod_c = {1'b0, sum_c};
        if (a[W-1] || b[W-1]) begin
            prod_c = INF;
        end
    end

    // OPLUS: infinity is the identity, otherwise unsigned minimum
    always_comb begin
        result_c = acc;
        if (acc[W-1]) begin
            result_c = prod_c;
        end else if (!prod_c[W-1] && (prod_c < acc)) begin
            result_c = prod_c;
        end
    end

endmodule

// File: rtl/tropical_mv_sequencer.sv
// Row-by-row min-plus matrix-vector product y = A (x) x with valid/ready result streaming.
module tropical_mv_sequencer
    import tropical_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_en,
    input  logic            load_sel,
    input  logic [IDXW-1:0] load_row,
    input  logic [IDXW-1:0] load_col,
    input  logic [W-1:0]    load_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            y_valid,
    input  logic            y_ready,
    output logic [IDXW-1:0] y_idx,
    output logic [W-1:0]    y_data
);

    state_t          state;
    logic [IDXW-1:0] row;
    logic [IDXW-1:0] col;
    logic [W-1:0]    acc;
    logic [W-1:0]    acc_next_c;

    logic [W-1:0]    a_buf [N][N];
    logic [W-1:0]    x_buf [N];

    tropical_op_unit u_op (
        .acc      (acc),
        .a        (a_buf[row][col]),
        .b        (x_buf[col]),
        .result_c (acc_next_c)
    );

    // Operand buffers: writable only while idle and not launching; contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n && load_en && (state == IDLE) && !start) begin
            if (load_sel) begin
                x_buf[load_col] <= load_data;
            end else begin
                a_buf[load_row][load_col] <= load_data;
            end
        end
    end

    // Schedule FSM with row/column counters, accumulator and registered result port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            y_valid <= 1'b0;
            y_idx   <= '0;
            y_data  <= '0;
            row     <= '0;
            col     <= '0;
            acc     <= INF;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ACC;
                        busy  <= 1'b1;
                        row   <= '0;
                        col   <= '0;
                        acc   <= INF;
                    end
                end
                ACC: begin
                    acc <= acc_next_c;
                    col <= IDXW'(col + 1'b1);
                    if (col == IDXW'(N - 1)) begin
                        state   <= OUT;
                        y_valid <= 1'b1;
                        y_data  <= acc_next_c;
                        y_idx   <= row;
                    end
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        if (row == IDXW'(N - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ACC;
                            row   <= IDXW'(row + 1'b1);
                            col   <= '0;
                            acc   <= INF;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tropical_mv_sequencer.sv
// Directed bench for tropical_mv_sequencer with hand-computed min-plus results.
module tb_tropical_mv_sequencer;

    localparam logic [31:0] INF = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic        load_sel;
    logic [1:0]  load_row;
    logic [1:0]  load_col;
    logic [31:0] load_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        y_valid;
    logic        y_ready;
    logic [1:0]  y_idx;
    logic [31:0] y_data;

    int          tests_run    = 0;
    int          tests_failed = 0;

    logic [31:0] got_y [4];
    int          first_valid;
    int          done_cyc;
    int          n_done;

    always #5 clk = ~clk;

    tropical_mv_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .load_row  (load_row),
        .load_col  (load_col),
        .load_data (load_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .y_idx     (y_idx),
        .y_data    (y_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_word(input bit sel, input int r, input int c, input logic [31:0] v);
        load_en   = 1'b1;
        load_sel  = sel;
        load_row  = 2'(r);
        load_col  = 2'(c);
        load_data = v;
        @(posedge clk); #1;
        load_en   = 1'b0;
    endtask

    task automatic load_row_a(input int r, input logic [31:0] v0, input logic [31:0] v1,
                              input logic [31:0] v2, input logic [31:0] v3);
        load_word(1'b0, r, 0, v0);
        load_word(1'b0, r, 1, v1);
        load_word(1'b0, r, 2, v2);
        load_word(1'b0, r, 3, v3);
    endtask

    task automatic load_x(input logic [31:0] v0, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] v3);
        load_word(1'b1, 0, 0, v0);
        load_word(1'b1, 0, 1, v1);
        load_word(1'b1, 0, 2, v2);
        load_word(1'b1, 0, 3, v3);
    endtask

    task automatic check_y(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
        check({tag, "_y0"}, got_y[0], e0);
        check({tag, "_y1"}, got_y[1], e1);
        check({tag, "_y2"}, got_y[2], e2);
        check({tag, "_y3"}, got_y[3], e3);
    endtask

    // One full run; cycle count 1 is the edge that samples start
    task automatic run(input int stall_row, input int stall_n, input bit inject, input bit load_with_start);
        int          cnt;
        int          stalls;
        bit          hold;
        logic [31:0] held;
        cnt = 0; stalls = 0; hold = 1'b0; held = '0;
        first_valid = 0; done_cyc = 0; n_done = 0;
        for (int j = 0; j < 4; j++) got_y[j] = 32'hDEAD_BEEF;
        y_ready = 1'b1;
        start   = 1'b1;
        if (load_with_start) begin
            load_en = 1'b1; load_sel = 1'b1; load_col = 2'd0; load_data = 32'd0;
        end
        while (done_cyc == 0 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
            start   = 1'b0;
            load_en = 1'b0;
            if (cnt == 1) check("busy_after_start", {31'd0, busy}, 32'd1);
            if (inject && cnt == 2) begin
                load_en = 1'b1; load_sel = 1'b1; load_col = 2'd0; load_data = 32'd0;
            end
            if (inject && cnt == 3) start = 1'b1;
            if (hold) begin
                check("stall_valid", {31'd0, y_valid}, 32'd1);
                check("stall_idx", {30'd0, y_idx}, 32'(stall_row));
                check("stall_data", y_data, held);
            end
            if (y_valid) begin
                if (first_valid == 0) first_valid = cnt;
                got_y[y_idx] = y_data;
                if (int'(y_idx) == stall_row && stalls < stall_n) begin
                    if (!hold) held = y_data;
                    hold    = 1'b1;
                    y_ready = 1'b0;
                    stalls++;
                end else begin
                    hold    = 1'b0;
                    y_ready = 1'b1;
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cnt;
            end
        end
        if (done_cyc == 0) check("run_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        check("done_single_pulse", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cnt;
        int pulses;
        rst_n = 1'b0; load_en = 1'b0; load_sel = 1'b0; load_row = '0; load_col = '0;
        load_data = '0; start = 1'b0; y_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_valid", {31'd0, y_valid}, 32'd0);
        check("rst_idx", {30'd0, y_idx}, 32'd0);
        check("rst_data", y_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity matrix passes x through
        load_row_a(0, 32'd0, INF, INF, INF);
        load_row_a(1, INF, 32'd0, INF, INF);
        load_row_a(2, INF, INF, 32'd0, INF);
        load_row_a(3, INF, INF, INF, 32'd0);
        load_x(32'd5, 32'd9, 32'd2, 32'd7);
        run(-1, 0, 1'b0, 1'b0);
        check_y("ident", 32'd5, 32'd9, 32'd2, 32'd7);
        check("ident_first_valid", 32'(first_valid), 32'd5);
        check("ident_done_cycle", 32'(done_cyc), 32'd21);
        check("ident_done_count", 32'(n_done), 32'd1);

        // General min-plus with an all-infinite row
        load_row_a(0, 32'd1, 32'd3, 32'd0, 32'd8);
        load_row_a(1, INF, INF, INF, INF);
        load_row_a(2, 32'd10, 32'd0, INF, 32'd1);
        load_row_a(3, 32'd2, 32'd2, 32'd2, 32'd2);
        load_x(32'd4, 32'd1, 32'd6, 32'd2);
        run(-1, 0, 1'b0, 1'b0);
        check_y("minplus", 32'd4, INF, 32'd1, 32'd3);
        check("minplus_done_cycle", 32'(done_cyc), 32'd21);

        // Backpressure on row 1 stretches the run by the stall length
        run(1, 5, 1'b0, 1'b0);
        check_y("stall", 32'd4, INF, 32'd1, 32'd3);
        check("stall_done_cycle", 32'(done_cyc), 32'd26);

        // Load and start while busy are dropped
        run(-1, 0, 1'b1, 1'b0);
        check_y("busy_load", 32'd4, INF, 32'd1, 32'd3);
        check("busy_load_done_count", 32'(n_done), 32'd1);

        // Load coincident with start is dropped
        run(-1, 0, 1'b0, 1'b1);
        check_y("load_start", 32'd4, INF, 32'd1, 32'd3);
        run(-1, 0, 1'b0, 1'b0);
        check_y("load_start_after", 32'd4, INF, 32'd1, 32'd3);

        // Reset during row 2 accumulation aborts without a done pulse
        start = 1'b1; y_ready = 1'b1; cnt = 0;
        while (cnt < 12) begin
            @(posedge clk); #1;
            cnt++;
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, y_valid}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run(-1, 0, 1'b0, 1'b0);
        check_y("rerun", 32'd4, INF, 32'd1, 32'd3);

        // Finite overflow wraps with the infinity bit cleared
        load_row_a(0, 32'h7FFF_FFFF, INF, INF, INF);
        load_row_a(1, 32'h0000_0010, 32'd0, 32'd0, 32'd0);
        load_row_a(2, INF, INF, INF, INF);
        load_row_a(3, 32'h7FFF_FFFE, 32'd5, 32'd5, 32'd5);
        load_x(32'd1, INF, INF, INF);
        run(-1, 0, 1'b0, 1'b0);
        check_y("ovf", 32'h0000_0000, 32'h0000_0011, INF, 32'h7FFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
